// File: rtl/ppa_pipe_adder_if.sv
// Operand/result streaming bundle for ppa_pipe_adder.
// master = upstream/downstream environment, slave = the adder.
interface ppa_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/ppa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with an elastic valid/ready pipeline.
// Carry-in sits at prefix position 0, so operand bit i lives at position i+1.
module ppa_pipe_adder #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic            clk,
    input  logic            rst,
    ppa_pipe_adder_if.slave bus
);
    localparam int N      = WIDTH + 1;
    localparam int LEVELS = $clog2(WIDTH + 1);
    localparam int STAGES = 1 + (LEVELS + REG_EVERY - 1) / REG_EVERY;
    localparam int NREG   = STAGES - 1;

    if (WIDTH < 2 || REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_bad_param
        $error("ppa_pipe_adder: WIDTH must be >= 2 and REG_EVERY within 1..LEVELS");
    end

    logic [N-1:0]      stg_p_q [0:NREG-1];
    logic [N-1:0]      stg_p_d [0:NREG-1];
    logic [N-1:0]      stg_g_q [0:NREG-1];
    logic [N-1:0]      stg_g_d [0:NREG-1];
    logic [WIDTH-1:0]  stg_o_q [0:NREG-1];
    logic [WIDTH-1:0]  stg_o_d [0:NREG-1];
    logic [STAGES-1:0] vld_q, vld_d, load;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [N-1:0]      row_p [1:LEVELS];
    logic [N-1:0]      row_g [1:LEVELS];
    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    // A stage loads when empty or when the stage after it is loading too.
    always_comb begin
        logic en;
        en   = bus.out_ready;
        load = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            en      = !vld_q[s] || en;
            load[s] = en;
        end
    end

    assign bus.in_ready  = load[0] && !rst;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
        c0    = bus.in_sub ? 1'b1 : bus.in_cin;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_row
        localparam int D = 1 << (k - 1);
        logic [N-1:0] src_p, src_g, out_p, out_g;

        if (((k - 1) % REG_EVERY) == 0) begin : g_from_reg
            assign src_p = stg_p_q[(k - 1) / REG_EVERY];
            assign src_g = stg_g_q[(k - 1) / REG_EVERY];
        end else begin : g_from_row
            assign src_p = row_p[k - 1];
            assign src_g = row_g[k - 1];
        end

        // Partners below 2*D already reach position 0, so only g is merged (grey cell).
        always_comb begin
            out_p = src_p;
            out_g = src_g;
            for (int j = D; j < N; j++) begin
                out_g[j] = src_g[j] | (src_p[j] & src_g[j - D]);
                if (j >= 2 * D) begin
                    out_p[j] = src_p[j] & src_p[j - D];
                end
            end
        end

        assign row_p[k] = out_p;
        assign row_g[k] = out_g;
    end

    always_comb begin
        vld_d   = vld_q;
        stg_p_d = stg_p_q;
        stg_g_d = stg_g_q;
        stg_o_d = stg_o_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (load[0]) begin
            vld_d[0]   = bus.in_valid;
            stg_o_d[0] = bus.in_a ^ b_eff;
            stg_p_d[0] = {bus.in_a ^ b_eff, 1'b0};
            stg_g_d[0] = {bus.in_a & b_eff, c0};
        end

        for (int s = 1; s < NREG; s++) begin
            if (load[s]) begin
                vld_d[s]   = vld_q[s - 1];
                stg_p_d[s] = row_p[s * REG_EVERY];
                stg_g_d[s] = row_g[s * REG_EVERY];
                stg_o_d[s] = stg_o_q[s - 1];
            end
        end

        // Output data only moves on a real result, so bubbles leave it untouched.
        if (load[STAGES-1]) begin
            vld_d[STAGES-1] = vld_q[STAGES-2];
            if (vld_q[STAGES-2]) begin
                sum_d  = stg_o_q[NREG-1] ^ row_g[LEVELS][WIDTH-1:0];
                cout_d = row_g[LEVELS][WIDTH];
                ovf_d  = row_g[LEVELS][WIDTH] ^ row_g[LEVELS][WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        stg_p_q <= stg_p_d;
        stg_g_q <= stg_g_d;
        stg_o_q <= stg_o_d;
    end
endmodule

// File: tb/tb_ppa_pipe_adder.sv
// Scoreboard bench for ppa_pipe_adder: driver pushes expected results, monitor pops on handshake.
module tb_ppa_pipe_adder;
    localparam int W = 16;
    localparam int R = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppa_pipe_adder_if #(.WIDTH(W)) bus ();
    ppa_pipe_adder #(.WIDTH(W), .REG_EVERY(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   occ      = 0;
    int   cyc      = 0;
    int   nv       = 0;
    int   first_v  = -1;
    int   last_v   = -1;
    int   exp_stages;
    logic held     = 1'b0;
    res_t held_r;
    res_t mon_e;

    // Stage count from first principles: prefix depth covers WIDTH+1 positions.
    function automatic int calcStages();
        int lv = 0;
        while ((1 << lv) < W + 1) lv++;
        return 1 + (lv + R - 1) / R;
    endfunction

    function automatic res_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input logic sub);
        res_t     r;
        logic [W:0] full;
        if (!sub) begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.sum  = full[W-1:0];
            r.cout = full[W];
            r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic ordy,
                                 input bit use_forced, input res_t forced,
                                 output logic acc, output logic ov);
        logic del;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.out_ready = ordy;
        #1;
        checkOutput("in_ready", 64'(bus.in_ready), (occ == exp_stages && !ordy) ? 64'd0 : 64'd1);
        acc = v && bus.in_ready;
        ov  = bus.out_valid;
        del = bus.out_valid && ordy;
        if (ov) begin
            nv++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        cyc++;
        @(posedge clk);
        if (acc) exp_q.push_back(use_forced ? forced : refModel(a, b, cin, sub));
        occ = occ + int'(acc) - int'(del);
    endtask

    task automatic randOp(input logic v, input logic ordy);
        logic acc, ov;
        applyStimulus(v, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy,
                      1'b0, '0, acc, ov);
    endtask

    task automatic drain(input string tag);
        logic acc, ov;
        int   k = 0;
        while ((exp_q.size() != 0 || occ != 0) && k < 60) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, ov);
            k++;
        end
        checkOutput({tag, "_drained"}, 64'(exp_q.size() == 0 && occ == 0), 64'd1);
    endtask

    // Monitor: compares each delivered result and checks that stalled outputs hold.
    always begin
        @(negedge clk);
        #2;
        if (rst !== 1'b0) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("hold_result", 64'({bus.out_sum, bus.out_cout, bus.out_ovf}), 64'(held_r));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("result", 64'({bus.out_sum, bus.out_cout, bus.out_ovf}), 64'(mon_e));
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_r = {bus.out_sum, bus.out_cout, bus.out_ovf};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc, ov;
        int   lat;
        bit   got;

        exp_stages    = calcStages();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_data", 64'({bus.out_sum, bus.out_cout, bus.out_ovf}), 64'd0);
        rst = 1'b0;
        occ = 0;

        $display("[TB] directed carry/borrow cases");
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0}, acc, ov);
        applyStimulus(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, {16'h8000, 1'b0, 1'b1}, acc, ov);
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0}, acc, ov);
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1}, acc, ov);
        drain("directed");

        $display("[TB] latency");
        randOp(1'b1, 1'b1);
        lat = -1;
        got = 1'b0;
        for (int i = 1; i <= 12 && !got; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, ov);
            if (ov) begin
                got = 1'b1;
                lat = i - 1;
            end
        end
        checkOutput("latency", 64'(lat), 64'(exp_stages - 1));
        drain("latency");

        $display("[TB] throughput");
        nv      = 0;
        first_v = -1;
        last_v  = -1;
        cyc     = 0;
        for (int i = 0; i < 100; i++) randOp(1'b1, 1'b1);
        drain("throughput");
        checkOutput("tput_count", 64'(nv), 64'd100);
        checkOutput("tput_span", 64'(last_v - first_v + 1), 64'd100);

        $display("[TB] backpressure");
        for (int i = 0; i < 400; i++) randOp(1'b1, 1'($urandom));
        drain("backpressure");

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) randOp(1'b1, 1'b1);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        exp_q.delete();
        occ = 0;
        @(negedge clk);
        #1;
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'({bus.out_sum, bus.out_cout, bus.out_ovf}), 64'd0);
        rst = 1'b0;
        nv  = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc, ov);
        checkOutput("no_stale_results", 64'(nv), 64'd0);
        randOp(1'b1, 1'b1);
        drain("after_reset");

        $display("[TB] random mixed traffic");
        for (int i = 0; i < 500; i++) randOp(($urandom % 4) != 0, ($urandom % 4) != 0);
        drain("mixed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
